// File: rtl/polling_controller.sv
// polling_controller: LTSSM Polling sub-state sequencer with ordered-set tx handshake and per-lane TS run counting
module polling_controller #(
  parameter int NUM_LANES      = 1,
  parameter int TX_TS1_MIN     = 1024,
  parameter int RX_CONSEC      = 8,
  parameter int TX_TS2_AFTER   = 16,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 compliance_en_i,
  input  logic [NUM_LANES-1:0] lanes_detected_i,
  input  logic [NUM_LANES-1:0] rx_ts1_i,
  input  logic [NUM_LANES-1:0] rx_ts2_i,
  input  logic [NUM_LANES-1:0] rx_other_i,
  output logic                 tx_os_req_o,
  output logic [1:0]           tx_os_type_o,
  input  logic                 tx_os_ack_i,
  output logic [2:0]           state_o,
  output logic                 done_o,
  output logic                 fail_o
);
  localparam int TXMAX = TX_TS1_MIN > TX_TS2_AFTER ? TX_TS1_MIN : TX_TS2_AFTER;
  localparam int TW = $clog2(TXMAX + 1);
  localparam int RW = $clog2(RX_CONSEC + 1);
  localparam int MW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACTIVE     = 3'd1,
    COMPLIANCE = 3'd2,
    CONFIG     = 3'd3,
    DONE       = 3'd4,
    FAIL       = 3'd5
  } state_t;
  state_t state, state_n;
  logic [NUM_LANES-1:0] mask, run_ok;
  logic [TW-1:0] txcnt;
  logic [MW-1:0] timer;
  logic seen_ts2, timeout, busy, counting, entry, clr, tx_inc, all_ok, any_ok, tx_min_ok, tx_after_ok;
  assign busy        = state == ACTIVE || state == COMPLIANCE || state == CONFIG;
  assign counting    = state == ACTIVE || state == CONFIG;
  assign timeout     = timer == MW'(TIMEOUT_CYCLES - 1);
  assign entry       = state_n != state;
  assign clr         = entry && (state_n == ACTIVE || state_n == CONFIG);
  assign all_ok      = &(run_ok | ~mask);
  assign any_ok      = |(run_ok & mask);
  assign tx_min_ok   = txcnt >= TW'(TX_TS1_MIN);
  assign tx_after_ok = txcnt >= TW'(TX_TS2_AFTER);
  // In CONFIG the tx count only starts once a TS2 has been seen on some lane
  assign tx_inc      = busy && tx_os_ack_i && (state != CONFIG || seen_ts2) && txcnt != '1;
  assign tx_os_req_o  = busy;
  assign tx_os_type_o = state == COMPLIANCE ? 2'd2 : state == CONFIG ? 2'd1 : 2'd0;
  assign state_o      = state;
  assign done_o       = state == DONE;
  assign fail_o       = state == FAIL;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start_i) state_n = |lanes_detected_i ? ACTIVE : FAIL;
      ACTIVE:     if (tx_min_ok && all_ok) state_n = CONFIG;
                  else if (timeout) state_n = tx_min_ok && any_ok ? CONFIG : compliance_en_i ? COMPLIANCE : FAIL;
      COMPLIANCE: if (|(rx_ts1_i & mask)) state_n = ACTIVE;
      CONFIG:     if (all_ok && tx_after_ok) state_n = DONE;
                  else if (timeout) state_n = FAIL;
      default:    state_n = IDLE;
    endcase
    if (abort_i) state_n = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mask     <= '0;
      timer    <= '0;
      txcnt    <= '0;
      seen_ts2 <= 1'b0;
    end else begin
      if (state == IDLE && start_i && !abort_i) mask <= lanes_detected_i;
      timer    <= entry ? '0 : busy && !timeout ? timer + MW'(1) : timer;
      txcnt    <= clr ? '0 : tx_inc ? txcnt + TW'(1) : txcnt;
      seen_ts2 <= clr ? 1'b0 : seen_ts2 | (state == CONFIG && |(rx_ts2_i & mask));
    end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [RW-1:0] run;
    logic inc, brk;
    assign inc = state == ACTIVE ? rx_ts1_i[g] | rx_ts2_i[g] : state == CONFIG && rx_ts2_i[g];
    // A malformed OS always breaks the run; in CONFIG a TS1 does too
    assign brk = counting && (rx_other_i[g] || (state == CONFIG && rx_ts1_i[g] && !rx_ts2_i[g]));
    assign run_ok[g] = run >= RW'(RX_CONSEC);
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) run <= '0;
      else if (clr) run <= '0;
      else if (mask[g] && brk) run <= '0;
      else if (mask[g] && inc && run != '1) run <= run + RW'(1);
  end
endmodule
